// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_ctrl
// Purpose  : Game-flow FSM for the falling-ball game. Generates per-frame step
//            and restart pulses and tracks the high score and the OVER blink.
// Revision : 1.0 - initial release
// ============================================================================
module game_ctrl #(
    parameter int TOP_LIMIT    = 2,
    parameter int OVER_FRAMES  = 180,
    parameter int BLINK_FRAMES = 30,
    parameter int SCORE_W      = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame,
    input  logic               btnS,
    input  logic [9:0]         ball_y,
    input  logic [SCORE_W-1:0] score,
    output logic               step,
    output logic               restart,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] highest,
    output logic               new_record,
    output logic               blink
);

    localparam int OVER_CNT_W = $clog2(OVER_FRAMES + 1);
    localparam int BLINK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [9:0]            c_top_limit = 10'(TOP_LIMIT);
    localparam logic [OVER_CNT_W-1:0] c_over_max  = OVER_CNT_W'(OVER_FRAMES);
    localparam logic [BLINK_W-1:0]    c_blink_max = BLINK_W'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  frame_d_q, btn_d_q;
    logic                  step_q, step_d;
    logic                  restart_q, restart_d;
    logic [SCORE_W-1:0]    highest_q, highest_d;
    logic                  new_record_q, new_record_d;
    logic                  blink_q, blink_d;
    logic [OVER_CNT_W-1:0] over_cnt_q, over_cnt_d;
    logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;

    logic w_frame_rise;
    logic w_press;
    logic w_ball_top;

    assign w_frame_rise = frame & ~frame_d_q;
    assign w_press      = btnS & ~btn_d_q;
    assign w_ball_top   = (ball_y < c_top_limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_READY;
            frame_d_q    <= 1'b0;
            btn_d_q      <= 1'b0;
            step_q       <= 1'b0;
            restart_q    <= 1'b0;
            highest_q    <= '0;
            new_record_q <= 1'b0;
            blink_q      <= 1'b0;
            over_cnt_q   <= '0;
            blink_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            frame_d_q    <= frame;
            btn_d_q      <= btnS;
            step_q       <= step_d;
            restart_q    <= restart_d;
            highest_q    <= highest_d;
            new_record_q <= new_record_d;
            blink_q      <= blink_d;
            over_cnt_q   <= over_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        step_d       = 1'b0;
        restart_d    = 1'b0;
        highest_d    = highest_q;
        new_record_d = new_record_q;
        blink_d      = blink_q;
        over_cnt_d   = over_cnt_q;
        blink_cnt_d  = blink_cnt_q;

        case (state_q)
            ST_READY: begin
                if (w_press) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // Game-over detection outranks a pause request on the same frame.
                if (w_frame_rise && w_ball_top) begin
                    state_d     = ST_OVER;
                    over_cnt_d  = '0;
                    blink_cnt_d = '0;
                    blink_d     = 1'b1;
                    if (score > highest_q) begin
                        highest_d    = score;
                        new_record_d = 1'b1;
                    end else begin
                        new_record_d = 1'b0;
                    end
                end else if (w_press) begin
                    state_d = ST_PAUSE;
                end else if (w_frame_rise) begin
                    step_d = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (w_press) begin
                    state_d = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (w_press && (over_cnt_q == c_over_max)) begin
                    state_d      = ST_READY;
                    restart_d    = 1'b1;
                    new_record_d = 1'b0;
                    blink_d      = 1'b0;
                    over_cnt_d   = '0;
                    blink_cnt_d  = '0;
                end else if (w_frame_rise) begin
                    if (over_cnt_q != c_over_max) begin
                        over_cnt_d = over_cnt_q + 1'b1;
                    end
                    if (blink_cnt_q == c_blink_max) begin
                        blink_cnt_d = '0;
                        blink_d     = ~blink_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    assign step       = step_q;
    assign restart    = restart_q;
    assign state      = state_q;
    assign highest    = highest_q;
    assign new_record = new_record_q;
    assign blink      = blink_q;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_ctrl
// Purpose  : Self-checking bench for game_ctrl: per-cycle vector table plus
//            hand-written OVER, record, and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_ctrl;

    logic        clk;
    logic        rst;
    logic        frame;
    logic        btnS;
    logic [9:0]  ball_y;
    logic [19:0] score;
    logic        step;
    logic        restart;
    logic [1:0]  state;
    logic [19:0] highest;
    logic        new_record;
    logic        blink;

    int n_cmp;
    int n_err;

    game_ctrl #(
        .TOP_LIMIT    (2),
        .OVER_FRAMES  (180),
        .BLINK_FRAMES (30),
        .SCORE_W      (20)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .frame      (frame),
        .btnS       (btnS),
        .ball_y     (ball_y),
        .score      (score),
        .step       (step),
        .restart    (restart),
        .state      (state),
        .highest    (highest),
        .new_record (new_record),
        .blink      (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        f;
        logic        b;
        logic [9:0]  y;
        logic [19:0] sc;
        logic [1:0]  st;
        logic        stp;
        logic        rs;
        logic [19:0] hi;
        logic        nr;
        logic        bl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic f, logic b, logic [9:0] y, logic [19:0] sc,
                                logic [1:0] st, logic stp, logic rs, logic [19:0] hi,
                                logic nr, logic bl);
        vec_t v;
        v.r = r; v.f = f; v.b = b; v.y = y; v.sc = sc;
        v.st = st; v.stp = stp; v.rs = rs; v.hi = hi; v.nr = nr; v.bl = bl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic stp,
                           input logic rs, input logic [19:0] hi, input logic nr,
                           input logic bl);
        chk({tag, ".state"},      32'(state),      32'(st));
        chk({tag, ".step"},       32'(step),       32'(stp));
        chk({tag, ".restart"},    32'(restart),    32'(rs));
        chk({tag, ".highest"},    32'(highest),    32'(hi));
        chk({tag, ".new_record"}, 32'(new_record), 32'(nr));
        chk({tag, ".blink"},      32'(blink),      32'(bl));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame = 1'b0;
            btnS  = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame = 1'b1;
            @(posedge clk);
            #1;
            chk("frame.step_in_over_or_idle", 32'(step), 32'(state == 2'd1 ? 1 : 0));
            @(negedge clk);
            frame = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_chk(input string name, input logic [1:0] exp_st, input logic exp_rs);
        @(negedge clk);
        btnS = 1'b1;
        @(posedge clk);
        #1;
        chk({name, ".state"},   32'(state),   32'(exp_st));
        chk({name, ".restart"}, 32'(restart), 32'(exp_rs));
        @(negedge clk);
        btnS = 1'b0;
        @(posedge clk);
        #1;
        chk({name, ".restart_off"}, 32'(restart), 32'd0);
    endtask

    task automatic end_game(input string name, input logic [19:0] sc,
                            input logic [19:0] exp_hi, input logic exp_nr);
        @(negedge clk);
        ball_y = 10'd1;
        score  = sc;
        frame  = 1'b1;
        @(posedge clk);
        #1;
        chk_all(name, 2'd3, 1'b0, 1'b0, exp_hi, exp_nr, 1'b1);
        @(negedge clk);
        frame  = 1'b0;
        ball_y = 10'd240;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst    = 1'b1;
        frame  = 1'b0;
        btnS   = 1'b0;
        ball_y = 10'd240;
        score  = 20'd0;

        //             r  f  b  y    sc   st stp rs hi  nr bl
        vecs.push_back(mk(1, 0, 0, 240, 0,   0, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 240, 0,   0, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 1, 0, 240, 0,   0, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 240, 0,   0, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 0, 1, 240, 0,   1, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 0, 1, 240, 0,   1, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 1, 1, 240, 0,   1, 1, 0, 0,   0, 0));
        vecs.push_back(mk(0, 1, 1, 240, 0,   1, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 240, 0,   1, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 1, 0, 240, 0,   1, 1, 0, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 240, 0,   1, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 0, 1, 240, 0,   2, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 1, 0, 240, 0,   2, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 240, 0,   2, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 1, 0, 1,   0,   2, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 0, 1, 240, 0,   1, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 1, 0, 2,   0,   1, 1, 0, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 240, 0,   1, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 1, 1, 240, 0,   2, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 240, 0,   2, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 0, 1, 240, 0,   1, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 1, 0, 1,   500, 3, 0, 0, 500, 1, 1));
        vecs.push_back(mk(0, 0, 0, 240, 500, 3, 0, 0, 500, 1, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst    = vecs[i].r;
            frame  = vecs[i].f;
            btnS   = vecs[i].b;
            ball_y = vecs[i].y;
            score  = vecs[i].sc;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].stp, vecs[i].rs,
                    vecs[i].hi, vecs[i].nr, vecs[i].bl);
        end

        // OVER hold-off and blink timing; 22 frame edges seen after entry so far: none.
        frames(10);
        press_chk("over_early_press", 2'd3, 1'b0);
        frames(19);
        chk("blink_after_29", 32'(blink), 32'd1);
        frames(1);
        chk("blink_after_30", 32'(blink), 32'd0);
        frames(149);
        press_chk("over_press_at_179", 2'd3, 1'b0);
        frames(1);
        press_chk("over_exit", 2'd0, 1'b1);
        chk_all("after_exit", 2'd0, 1'b0, 1'b0, 20'd500, 1'b0, 1'b0);

        // Tie with the record, then a lower score.
        press_chk("game2_start", 2'd1, 1'b0);
        end_game("game2_tie", 20'd500, 20'd500, 1'b0);
        frames(180);
        press_chk("game2_exit", 2'd0, 1'b1);
        press_chk("game3_start", 2'd1, 1'b0);
        end_game("game3_low", 20'd300, 20'd500, 1'b0);
        frames(180);
        press_chk("game3_exit", 2'd0, 1'b1);
        chk("highest_kept_after_restart", 32'(highest), 32'd500);

        // Asynchronous reset in the middle of a step pulse.
        press_chk("game4_start", 2'd1, 1'b0);
        @(negedge clk);
        frame = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_rst.step", 32'(step), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 2'd0, 1'b0, 1'b0, 20'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst   = 1'b0;
        frame = 1'b0;
        @(posedge clk);
        #1;
        chk_all("post_rst", 2'd0, 1'b0, 1'b0, 20'd0, 1'b0, 1'b0);

        // Game-over and press on the same frame edge: OVER wins.
        press_chk("game5_start", 2'd1, 1'b0);
        @(negedge clk);
        btnS   = 1'b1;
        frame  = 1'b1;
        ball_y = 10'd1;
        score  = 20'd7;
        @(posedge clk);
        #1;
        chk_all("over_vs_press", 2'd3, 1'b0, 1'b0, 20'd7, 1'b1, 1'b1);
        idle(1);
        ball_y = 10'd240;

        // Button held for 50 cycles gives a single transition.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        btnS = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
        end
        chk("held_button.state", 32'(state), 32'd1);
        idle(2);
        chk("held_release.state", 32'(state), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
